// File: rtl/skinny_sb_ti2_seq.sv
// Byte-serial front end for a 3-share SKINNY S8 threshold core.
// Each share lane is handled on its own; no logic ever mixes two shares.
module skinny_sb_ti2_seq #(
  parameter int SBOX_LAT = 4,
  parameter int NBYTES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   s0_i,
  input  logic [8*NBYTES-1:0]   s1_i,
  input  logic [8*NBYTES-1:0]   s2_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   s0_o,
  output logic [8*NBYTES-1:0]   s1_o,
  output logic [8*NBYTES-1:0]   s2_o,
  output logic [7:0]            sb_si0,
  output logic [7:0]            sb_si1,
  output logic [7:0]            sb_si2,
  input  logic [7:0]            sb_bo0,
  input  logic [7:0]            sb_bo1,
  input  logic [7:0]            sb_bo2,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (SBOX_LAT > 0) ? $clog2(SBOX_LAT + 1) : 1;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAT_C   = CW'(SBOX_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] LAST_C  = IW'(NBYTES - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_st0;
  logic [W-1:0]    r_st1;
  logic [W-1:0]    r_st2;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic            w_run;
  logic            w_accept;
  logic            w_capture;
  logic            w_last;

  assign w_run     = (r_state == ST_RUN);
  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_capture = w_run && (r_cnt == LAT_C);
  assign w_last    = (r_idx == LAST_C);

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = w_run;
  assign s0_o      = r_st0;
  assign s1_o      = r_st1;
  assign s2_o      = r_st2;
  // The core sees zeros outside RUN so idle shares never toggle its inputs.
  assign sb_si0    = w_run ? r_st0[7:0] : 8'h00;
  assign sb_si1    = w_run ? r_st1[7:0] : 8'h00;
  assign sb_si2    = w_run ? r_st2[7:0] : 8'h00;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_capture && w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Settle counter and byte index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_capture) begin
      r_cnt <= '0;
      r_idx <= w_last ? '0 : (r_idx + IDX_ONE);
    end else if (w_run) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Share state registers: load on accept, rotate a result byte in on each capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st0 <= '0;
      r_st1 <= '0;
      r_st2 <= '0;
    end else if (w_accept) begin
      r_st0 <= s0_i;
      r_st1 <= s1_i;
      r_st2 <= s2_i;
    end else if (w_capture) begin
      r_st0 <= {sb_bo0, r_st0[W-1:8]};
      r_st1 <= {sb_bo1, r_st1[W-1:8]};
      r_st2 <= {sb_bo2, r_st2[W-1:8]};
    end
  end

endmodule

// File: tb/tb_skinny_sb_ti2_seq.sv
// Directed bench for skinny_sb_ti2_seq with a behavioural 4-stage shared S-box core.
module tb_skinny_sb_ti2_seq;

  localparam int W = 128;
  localparam logic [127:0] X_VEC = 128'h0f0e0d0c0b0a09080706050403020100;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s0_i, s1_i, s2_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s0_o, s1_o, s2_o;
  logic [7:0]   sb_si0, sb_si1, sb_si2;
  logic [7:0]   sb_bo0, sb_bo1, sb_bo2;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skinny_sb_ti2_seq #(.SBOX_LAT(4), .NBYTES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .s0_i(s0_i), .s1_i(s1_i), .s2_i(s2_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .s0_o(s0_o), .s1_o(s1_o), .s2_o(s2_o),
    .sb_si0(sb_si0), .sb_si1(sb_si1), .sb_si2(sb_si2),
    .sb_bo0(sb_bo0), .sb_bo1(sb_bo1), .sb_bo2(sb_bo2),
    .busy(busy)
  );

  function automatic logic [7:0] f_mix(input logic [7:0] x);
    return ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
  endfunction

  function automatic logic [7:0] f_perm(input logic [7:0] x);
    return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
           ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] x_in);
    logic [7:0] x;
    x = f_mix(x_in);
    x = f_perm(x);
    x = f_mix(x);
    x = f_perm(x);
    x = f_mix(x);
    x = f_perm(x);
    x = f_mix(x);
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  // Deterministic output masks so every output share is predictable.
  function automatic logic [7:0] mask1(input logic [7:0] b);
    return {b[6:0], b[7]} ^ 8'h3c;
  endfunction

  function automatic logic [7:0] mask2(input logic [7:0] c);
    return {c[0], c[7:1]} ^ 8'hc5;
  endfunction

  function automatic logic [W-1:0] exp_share(input int n, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] r;
    logic [7:0] m1, m2, y;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      m1 = mask1(b[8*k +: 8]);
      m2 = mask2(c[8*k +: 8]);
      y  = sbox8(a[8*k +: 8] ^ b[8*k +: 8] ^ c[8*k +: 8]);
      if (n == 0)      r[8*k +: 8] = y ^ m1 ^ m2;
      else if (n == 1) r[8*k +: 8] = m1;
      else             r[8*k +: 8] = m2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] unmasked_exp(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox8(x[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Behavioural shared S-box core: four register stages from si to bo.
  logic [7:0] p_y [4];
  logic [7:0] p_m1 [4];
  logic [7:0] p_m2 [4];
  always @(posedge clk) begin
    p_y[0]  <= sbox8(sb_si0 ^ sb_si1 ^ sb_si2);
    p_m1[0] <= mask1(sb_si1);
    p_m2[0] <= mask2(sb_si2);
    for (int i = 1; i < 4; i++) begin
      p_y[i]  <= p_y[i-1];
      p_m1[i] <= p_m1[i-1];
      p_m2[i] <= p_m2[i-1];
    end
  end
  assign sb_bo0 = p_y[3] ^ p_m1[3] ^ p_m2[3];
  assign sb_bo1 = p_m1[3];
  assign sb_bo2 = p_m2[3];

  task automatic start_state(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    @(negedge clk);
    s0_i = a; s1_i = b; s2_i = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s0_i = '0; s1_i = '0; s2_i = '0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || {s0_o, s1_o, s2_o} !== '0 ||
        {sb_si0, sb_si1, sb_si2} !== 24'h0) begin
      errors++;
      $display("FAIL reset_init: ov/busy/ir=%b s0_o=%h sb_si=%h%h%h, required 001 and zeros",
               {out_valid, busy, in_ready}, s0_o, sb_si0, sb_si1, sb_si2);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_functional();
    logic [W-1:0] b, c, a, xr;
    int n;
    b = rnd128(); c = rnd128(); a = X_VEC ^ b ^ c;
    start_state(a, b, c);
    wait_done(n);
    checks++;
    if (n !== 80) begin
      errors++;
      $display("FAIL func_latency: got %0d edges, required 80", n);
    end
    xr = s0_o ^ s1_o ^ s2_o;
    checks++;
    if (xr[31:0] !== 32'h426a4c65) begin
      errors++;
      $display("FAIL func_low_bytes: got %h, required 426a4c65", xr[31:0]);
    end
    checks++;
    if (xr !== unmasked_exp(X_VEC)) begin
      errors++;
      $display("FAIL func_unmasked: got %h, required %h", xr, unmasked_exp(X_VEC));
    end
    checks++;
    if (s0_o !== exp_share(0, a, b, c) || s1_o !== exp_share(1, a, b, c) ||
        s2_o !== exp_share(2, a, b, c)) begin
      errors++;
      $display("FAIL func_shares: s0_o=%h s1_o=%h s2_o=%h, required %h %h %h", s0_o, s1_o, s2_o,
               exp_share(0, a, b, c), exp_share(1, a, b, c), exp_share(2, a, b, c));
    end
    release_out();
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || s0_o !== exp_share(0, a, b, c)) begin
      errors++;
      $display("FAIL func_release: ov/busy/ir=%b s0_o=%h, required 001 and retained state",
               {out_valid, busy, in_ready}, s0_o);
    end
  endtask

  task automatic test_timing();
    logic [W-1:0] b, c, a;
    logic [7:0] e0, e1, e2;
    b = rnd128(); c = rnd128(); a = X_VEC ^ b ^ c;
    start_state(a, b, c);
    for (int j = 0; j < 80; j++) begin
      e0 = a[8*(j/5) +: 8]; e1 = b[8*(j/5) +: 8]; e2 = c[8*(j/5) +: 8];
      checks++;
      if ({sb_si0, sb_si1, sb_si2} !== {e0, e1, e2} || {out_valid, busy, in_ready} !== 3'b010) begin
        errors++;
        $display("FAIL timing_cycle%0d: sb_si=%h%h%h ov/busy/ir=%b, required %h%h%h and 010",
                 j, sb_si0, sb_si1, sb_si2, {out_valid, busy, in_ready}, e0, e1, e2);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b100 || {sb_si0, sb_si1, sb_si2} !== 24'h0) begin
      errors++;
      $display("FAIL timing_done: ov/busy/ir=%b sb_si=%h%h%h, required 100 and zeros",
               {out_valid, busy, in_ready}, sb_si0, sb_si1, sb_si2);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] b, c, a, h0, h1, h2;
    int n;
    b = rnd128(); c = rnd128(); a = X_VEC ^ b ^ c;
    start_state(a, b, c);
    wait_done(n);
    h0 = exp_share(0, a, b, c); h1 = exp_share(1, a, b, c); h2 = exp_share(2, a, b, c);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      in_valid = j[0]; s0_i = rnd128(); s1_i = rnd128(); s2_i = rnd128();
      @(posedge clk); #1;
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b100 || {s0_o, s1_o, s2_o} !== {h0, h1, h2}) begin
        errors++;
        $display("FAIL bp_hold%0d: ov/busy/ir=%b s0_o=%h, required 100 and %h",
                 j, {out_valid, busy, in_ready}, s0_o, h0);
      end
    end
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || {s0_o, s1_o, s2_o} !== {h0, h1, h2}) begin
      errors++;
      $display("FAIL bp_release: ov/busy/ir=%b s0_o=%h, required 001 with no new accept",
               {out_valid, busy, in_ready}, s0_o);
    end
  endtask

  task automatic test_reset_done();
    logic [W-1:0] b, c;
    int n;
    b = rnd128(); c = rnd128();
    start_state(X_VEC ^ b ^ c, b, c);
    wait_done(n);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || {s0_o, s1_o, s2_o} !== '0) begin
      errors++;
      $display("FAIL reset_done: ov/busy/ir=%b s0_o=%h, required 001 and zeros",
               {out_valid, busy, in_ready}, s0_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] b, c;
    int seen;
    b = rnd128(); c = rnd128();
    start_state(X_VEC ^ b ^ c, b, c);
    repeat (36) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || {s0_o, s1_o, s2_o} !== '0 ||
        {sb_si0, sb_si1, sb_si2} !== 24'h0) begin
      errors++;
      $display("FAIL reset_midrun: ov/busy/ir=%b s0_o=%h sb_si=%h%h%h, required 001 and zeros",
               {out_valid, busy, in_ready}, s0_o, sb_si0, sb_si1, sb_si2);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int j = 0; j < 100; j++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_output: %0d cycles with out_valid/busy set, required 0", seen);
    end
    test_functional();
  endtask

  task automatic test_random_shares();
    logic [W-1:0] b, c, a;
    logic [7:0] xb, mb;
    int n, leaks;
    for (int r = 0; r < 100; r++) begin
      b = rnd128(); c = rnd128(); a = X_VEC ^ b ^ c;
      start_state(a, b, c);
      leaks = 0;
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
        xb = X_VEC[8*((n/5)%16) +: 8];
        mb = b[8*((n/5)%16) +: 8] ^ c[8*((n/5)%16) +: 8];
        if (busy === 1'b1 && sb_si0 === xb && mb !== 8'h00) leaks++;
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n !== 80 || (s0_o ^ s1_o ^ s2_o) !== unmasked_exp(X_VEC)) begin
        errors++;
        $display("FAIL rand_run%0d: latency %0d result %h, required 80 and %h",
                 r, n, s0_o ^ s1_o ^ s2_o, unmasked_exp(X_VEC));
      end
      checks++;
      if (s1_o !== exp_share(1, a, b, c) || s2_o !== exp_share(2, a, b, c)) begin
        errors++;
        $display("FAIL rand_shares%0d: s1_o=%h s2_o=%h, required %h %h",
                 r, s1_o, s2_o, exp_share(1, a, b, c), exp_share(2, a, b, c));
      end
      checks++;
      if (leaks != 0) begin
        errors++;
        $display("FAIL rand_mask%0d: %0d unmasked bytes on sb_si0, required 0", r, leaks);
      end
      release_out();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_functional();
    test_timing();
    test_backpressure();
    test_reset_done();
    test_reset_midrun();
    test_random_shares();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
